// File: rtl/pipelined_cla_sub_32bit_pkg.sv
`default_nettype none
// ============================================================================
// pipelined_cla_sub_32bit_pkg : shared sizes and stage payload for the subtractor
// Rev 1.0
// ============================================================================
package pipelined_cla_sub_32bit_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_GROUP  = 8;
  localparam int NUM_STAGES = DEF_WIDTH / DEF_GROUP;

  // Operands ride along at full width; each stage fills its own slice of diff_lo.
  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] a_hi;
    logic [DEF_WIDTH-1:0] b_hi;
    logic [DEF_WIDTH-1:0] diff_lo;
    logic                 carry;
  } stage_t;

endpackage
`default_nettype wire

// File: rtl/pipelined_cla_sub_32bit_if.sv
`default_nettype none
// ============================================================================
// pipelined_cla_sub_32bit_if : valid/ready operand and result bus
// Rev 1.0
// ============================================================================
interface pipelined_cla_sub_32bit_if
  import pipelined_cla_sub_32bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, A, B, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );

  modport slave (
    input  in_valid, A, B, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );

endinterface
`default_nettype wire

// File: rtl/pipelined_cla_sub_32bit_cla_slice_8.sv
`default_nettype none
// ============================================================================
// cla_slice_8 : combinational 8-bit carry-lookahead adder slice (a + b_inv + cin)
// Rev 1.0
// ============================================================================
module cla_slice_8
  import pipelined_cla_sub_32bit_pkg::*;
(
  input  logic [DEF_GROUP-1:0] a,
  input  logic [DEF_GROUP-1:0] b_inv,
  input  logic                 cin,
  output logic [DEF_GROUP-1:0] s,
  output logic                 cout
);

  logic [DEF_GROUP-1:0] g;
  logic [DEF_GROUP-1:0] p;
  logic [DEF_GROUP:0]   c;

  assign g = a & b_inv;
  assign p = a ^ b_inv;

  // Each carry is the flat sum-of-products of generates and propagate chains.
  always_comb begin
    logic term;
    logic any;
    c    = '0;
    term = 1'b0;
    any  = 1'b0;
    c[0] = cin;
    for (int i = 0; i < DEF_GROUP; i++) begin
      any = 1'b0;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        any = any | term;
      end
      term = cin;
      for (int m = 0; m <= i; m++) term = term & p[m];
      c[i+1] = any | term;
    end
  end

  assign s    = p ^ c[DEF_GROUP-1:0];
  assign cout = c[DEF_GROUP];

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_sub_32bit.sv
`default_nettype none
// ============================================================================
// pipelined_cla_sub_32bit : 4-stage staircase CLA subtractor, A - B - bin, valid/ready
// Rev 1.0
// ============================================================================
module pipelined_cla_sub_32bit
  import pipelined_cla_sub_32bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic                    clk,
  input  logic                    rst,
  pipelined_cla_sub_32bit_if.slave bus
);

  if (WIDTH != DEF_WIDTH || GROUP != DEF_GROUP) begin : g_param_check
    $error("pipelined_cla_sub_32bit: WIDTH/GROUP must match the package payload layout");
  end

  logic             stall;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // A held output freezes every stage, so nothing ahead of it can be overwritten.
  assign stall        = out_valid_q && !bus.out_ready;
  assign bus.in_ready = !stall;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    stage_t           cur;
    stage_t           stg_d;
    logic [GROUP-1:0] s;
    logic             cout;

    if (k == 0) begin : g_head
      assign cur = {bus.in_valid, bus.A, bus.B, {WIDTH{1'b0}}, ~bus.bin};
    end else begin : g_link
      assign cur = g_stage[k-1].g_reg.stg_q;
    end

    cla_slice_8 u_slice (
      .a     (cur.a_hi[k*GROUP +: GROUP]),
      .b_inv (~cur.b_hi[k*GROUP +: GROUP]),
      .cin   (cur.carry),
      .s     (s),
      .cout  (cout)
    );

    always_comb begin
      stg_d                           = cur;
      stg_d.diff_lo[k*GROUP +: GROUP] = s;
      stg_d.carry                     = cout;
    end

    if (k < NUM_STAGES - 1) begin : g_reg
      stage_t stg_q;
      always_ff @(posedge clk) begin
        if (rst)         stg_q <= '0;
        else if (!stall) stg_q <= stg_d;
      end
    end
  end

  stage_t fin;
  logic   unused_fin;
  assign fin        = g_stage[NUM_STAGES-1].stg_d;
  assign unused_fin = ^{fin.a_hi[WIDTH-2:0], fin.b_hi[WIDTH-2:0]};

  // Last stage folds the flags in so they register alongside diff.
  always_comb begin
    out_valid_d = fin.valid;
    diff_d      = fin.diff_lo;
    bout_d      = ~fin.carry;
    ovf_d       = (fin.a_hi[WIDTH-1] != fin.b_hi[WIDTH-1]) &&
                  (fin.diff_lo[WIDTH-1] != fin.a_hi[WIDTH-1]);
    zero_d      = ~|fin.diff_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_sub_32bit.sv
`default_nettype none
// ============================================================================
// tb_pipelined_cla_sub_32bit : directed + random scoreboard bench for the subtractor
// Rev 1.0
// ============================================================================
module tb_pipelined_cla_sub_32bit;

  logic clk = 1'b0;
  logic rst;

  pipelined_cla_sub_32bit_if bus ();

  pipelined_cla_sub_32bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [34:0] sb [$];
  int          sent;
  int          delivered;
  int          hold_idx;
  bit          started;
  logic [34:0] held;
  logic        acc;
  logic        irdy;
  logic        v;
  logic        ordy;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        rbi;

  // Expected {bout, ovf, zero, diff} straight from unsigned and signed arithmetic.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic bi);
    logic [32:0] r;
    longint      sd;
    logic        ov;
    r  = {1'b0, a} - {1'b0, b} - {32'b0, bi};
    sd = longint'($signed(a)) - longint'($signed(b)) - longint'({63'b0, bi});
    ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {r[32], ov, (r[31:0] == 32'h0), r[31:0]};
  endfunction

  function automatic logic [34:0] obs_out();
    return {bus.bout, bus.ovf, bus.zero, bus.diff};
  endfunction

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of traffic: drive, settle, score handshakes, then advance one edge.
  task automatic cyc(input logic iv, input logic [31:0] a, input logic [31:0] b,
                     input logic bi, input logic ordy_i, output logic acc_o, output logic irdy_o);
    bus.in_valid  = iv;
    bus.A         = a;
    bus.B         = b;
    bus.bin       = bi;
    bus.out_ready = ordy_i;
    #1;
    irdy_o = bus.in_ready;
    acc_o  = iv && bus.in_ready;
    if (bus.out_valid && ordy_i) begin
      chk("sb_pop_avail", {34'b0, sb.size() != 0}, 35'd1);
      if (sb.size() != 0) chk("sb_data", obs_out(), sb.pop_front());
      delivered++;
    end
    if (acc_o) sb.push_back(model(a, b, bi));
    @(posedge clk);
    #1;
  endtask

  // Single item into an idle pipe: checks edge count to out_valid and the result.
  task automatic dir(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic bi, input logic [34:0] exp);
    int lat;
    bus.in_valid  = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.bin       = bi;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 35'(lat), 35'd4);
    chk(tag, obs_out(), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {34'b0, bus.out_valid}, 35'd0);
    chk("rst_outputs", obs_out(), 35'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {34'b0, bus.in_ready}, 35'd1);

    dir("sub_5_3",        32'd5,         32'd3,         1'b0, {1'b0, 1'b0, 1'b0, 32'h00000002});
    dir("sub_0_1",        32'd0,         32'd1,         1'b0, {1'b1, 1'b0, 1'b0, 32'hFFFFFFFF});
    dir("sub_min_1",      32'h80000000,  32'd1,         1'b0, {1'b0, 1'b1, 1'b0, 32'h7FFFFFFF});
    dir("sub_max_neg1",   32'h7FFFFFFF,  32'hFFFFFFFF,  1'b0, {1'b1, 1'b1, 1'b0, 32'h80000000});
    dir("sub_equal",      32'hDEADBEEF,  32'hDEADBEEF,  1'b0, {1'b0, 1'b0, 1'b1, 32'h00000000});
    dir("sub_equal_bin",  32'hDEADBEEF,  32'hDEADBEEF,  1'b1, {1'b1, 1'b0, 1'b0, 32'hFFFFFFFF});

    // Six back-to-back items with a three-cycle output stall at the first result.
    sent = 0; delivered = 0; hold_idx = 0; started = 1'b0; held = '0;
    for (int cy = 0; cy < 40 && delivered < 6; cy++) begin
      if (bus.out_valid && !started) begin
        started = 1'b1;
        held    = obs_out();
      end
      if (started && hold_idx >= 1 && hold_idx <= 3) chk("stall_hold", obs_out(), held);
      ordy = !(started && hold_idx < 3);
      ra = $urandom; rb = $urandom; rbi = 1'($urandom_range(0, 1));
      cyc(sent < 6, ra, rb, rbi, ordy, acc, irdy);
      if (started && hold_idx < 3) chk("stall_in_ready", {34'b0, irdy}, 35'd0);
      if (acc) sent++;
      if (started) hold_idx++;
    end
    chk("stall_delivered", 35'(delivered), 35'd6);
    chk("stall_sb_empty", 35'(sb.size()), 35'd0);

    // Reset with three items in flight flushes them all.
    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      cyc(1'b1, ra, rb, 1'b0, 1'b1, acc, irdy);
    end
    rst = 1'b1;
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc, irdy);
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      chk("flush_out_valid", {34'b0, bus.out_valid}, 35'd0);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc, irdy);
    end
    dir("post_rst_1_1", 32'd1, 32'd1, 1'b0, {1'b0, 1'b0, 1'b1, 32'h00000000});

    // Random traffic with random in_valid and out_ready against the scoreboard.
    sent = 0; delivered = 0;
    for (int cy = 0; cy < 20000 && (sent < 1000 || sb.size() != 0); cy++) begin
      v    = (sent < 1000) && ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      ra   = $urandom;
      rb   = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      rbi  = 1'($urandom_range(0, 1));
      cyc(v, ra, rb, rbi, ordy, acc, irdy);
      if (acc) sent++;
    end
    chk("rand_sent", 35'(sent), 35'd1000);
    chk("rand_delivered", 35'(delivered), 35'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
